wb_project_selector: RTL and testbench
======================================

Name: wb_project_selector

Overview:
- Wishbone-controlled multi-project IO selector for the user area, driven from the Wishbone clock domain.
- Routes io_out/io_oeb of exactly one of NUM_PROJECTS wrapped designs to the pads and holds every other project in reset.
- On every project change, runs a guarded switch-over sequence: pads tristated, all projects reset for GUARD_CYCLES.
- Projects tap io_in directly; this block only handles the output path, the resets and the control registers.

Parameters:
- NUM_PROJECTS, 4, number of wrapped projects (1..255).
- IO_WIDTH, 38, pad count routed per project.
- BASE_ADDR, 32'h3000_0000, Wishbone window base; bits [3:0] are ignored.
- GUARD_CYCLES, 16, switch-over hold time in clocks (>=1).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- proj_io_out  in  NUM_PROJECTS*IO_WIDTH  project outputs, project k at [k*IO_WIDTH +: IO_WIDTH].
- proj_io_oeb  in  NUM_PROJECTS*IO_WIDTH  project output enables (active-low), same packing.
- proj_rst  out  NUM_PROJECTS  per-project reset, active-high.
- io_out  out  IO_WIDTH  pad outputs.
- io_oeb  out  IO_WIDTH  pad output enables, active-low.

Behaviour:
- Reset values (asynchronous assertion):
  - state=IDLE; CTRL=0; STATUS=0.
  - wbs_ack_o=0, wbs_dat_o=0.
  - proj_rst all 1, io_out all 0, io_oeb all 1.
- Decode: hit when wbs_adr_i[31:4]==BASE_ADDR[31:4]; offset = wbs_adr_i[3:2].
- Wishbone handshake:
  - wbs_ack_o registered: ack <= cyc & stb & hit & ~ack.
  - One-cycle pulse, so latency is one clock.
  - Back-to-back held strobes ack every other cycle.
  - A miss is never acked.
- Writes take effect on the ack cycle and honour wbs_sel_i per byte.
- Reads: wbs_dat_o is registered with the ack and is 0 when not acking. Unused offsets read 0; writes to them are ignored.
- Register 0x0 CTRL (R/W): [7:0] req_sel, [31] enable.
- Register 0x4 STATUS (RO):
  - [7:0] act_sel; [9:8] state (IDLE=0, RUN=1, DRAIN=2).
  - [16] bad_sel, sticky; cleared by the next CTRL write that holds a valid req_sel.
  - [17] wdt_fired, sticky; cleared by any CTRL write.
- Register 0x8 SWCOUNT (RO): 16-bit count of completed DRAINs; wraps at 0xFFFF -> 0.
- FSM (target = enable && req_sel<NUM_PROJECTS):
  - IDLE: all proj_rst=1; pads tristated (io_oeb=1, io_out=0). If target, go to DRAIN.
  - DRAIN: same pad/reset state as IDLE. Guard counter loads GUARD_CYCLES-1 on entry and decrements each cycle. At 0: SWCOUNT++; latch act_sel=req_sel; go to RUN if target, else IDLE.
  - RUN: proj_rst[act_sel]=0, all others 1. io_out and io_oeb are registered copies of slice act_sel, so one cycle of latency. If CTRL changes so that req_sel!=act_sel or enable=0, go to DRAIN; the pads tristate in the first DRAIN cycle.
- CTRL writes during DRAIN do not restart the guard counter; the exit decision uses CTRL as it stands at exit.
- req_sel>=NUM_PROJECTS with enable=1: bad_sel set, treated as disabled, no project selected.
- Reset mid-DRAIN or mid-RUN: immediate return to IDLE outputs; SWCOUNT cleared.

Optional Feature:
- Macro: SELECTOR_WATCHDOG_EN.
- When defined:
  - Register 0xC WDT (R/W, 16 bits).
  - A write loads both the reload value and the counter.
  - In RUN with reload!=0, the counter decrements each cycle.
  - Reaching 0 sets wdt_fired, clears CTRL.enable and enters DRAIN (then IDLE).
  - DRAIN/IDLE hold the counter at its reload value.
- When undefined: offset 0xC reads 0, writes are ignored, wdt_fired always reads 0.

Test Plan:
- Reset, then read STATUS and SWCOUNT -> 0x0 and 0x0; io_oeb all 1; proj_rst=4'b1111; ack arrives 1 cycle after stb.
- Write CTRL=0x8000_0002 -> 16 DRAIN cycles with pads tristated -> RUN; proj_rst=4'b1011; io_out follows proj_io_out slice 2 one cycle late; SWCOUNT=1.
- In RUN on project 2, write CTRL=0x8000_0000 -> pads tristated the next cycle; after 16 cycles act_sel=0, proj_rst=4'b1110; SWCOUNT=2.
- Write CTRL=0x8000_0007 (NUM_PROJECTS=4) -> STATUS bad_sel=1, state IDLE, all resets high; access at BASE_ADDR+0x10 -> no ack.
- Byte write CTRL with sel=4'b0001, data 0x03 while enable is set -> req_sel=3, enable still 1; assert wb_rst_i mid-DRAIN -> outputs at reset values on the same edge.
- With SELECTOR_WATCHDOG_EN: in RUN write WDT=5 -> after 5 cycles STATUS wdt_fired=1, enable=0, then DRAIN -> IDLE.

Source files
------------

// File: rtl/wb_project_selector.sv
// Wishbone-controlled selector: routes one wrapped project's pads out, holds the others in reset,
// and guards every switch-over with a tristated reset window. SELECTOR_WATCHDOG_EN adds the WDT register.
module wb_project_selector #(
    parameter int          NUM_PROJECTS = 4,
    parameter int          IO_WIDTH     = 38,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          GUARD_CYCLES = 16
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic                             wbs_cyc_i,
    input  logic                             wbs_stb_i,
    input  logic                             wbs_we_i,
    input  logic [3:0]                       wbs_sel_i,
    input  logic [31:0]                      wbs_adr_i,
    input  logic [31:0]                      wbs_dat_i,
    output logic                             wbs_ack_o,
    output logic [31:0]                      wbs_dat_o,
    input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_out,
    input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_oeb,
    output logic [NUM_PROJECTS-1:0]          proj_rst,
    output logic [IO_WIDTH-1:0]              io_out,
    output logic [IO_WIDTH-1:0]              io_oeb
);
    localparam int         GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [8:0] NP = 9'(NUM_PROJECTS);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

    state_t              r_state, r_state_next;
    logic [7:0]          r_req_sel, r_act_sel, w_act_sel_next, w_new_sel;
    logic                r_enable, r_bad_sel, r_ack;
    logic [31:0]         r_dat, w_rd_data;
    logic [15:0]         r_swcount, w_wdt_rd;
    logic [GW-1:0]       r_guard;
    logic [IO_WIDTH-1:0] r_io_out, r_io_oeb, w_sel_out, w_sel_oeb;
    logic [IO_WIDTH-1:0] w_slice_out [NUM_PROJECTS];
    logic [IO_WIDTH-1:0] w_slice_oeb [NUM_PROJECTS];
    logic                w_hit, w_req, w_ctrl_wr, w_target, w_req_ok, w_new_sel_ok;
    logic                w_drain_done, w_wdt_expire, w_wdt_fired, w_unused;

    assign w_hit        = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_req        = wbs_cyc_i && wbs_stb_i && w_hit && !r_ack;
    assign w_ctrl_wr    = w_req && wbs_we_i && (wbs_adr_i[3:2] == 2'd0);
    assign w_new_sel    = wbs_sel_i[0] ? wbs_dat_i[7:0] : r_req_sel;
    assign w_new_sel_ok = ({1'b0, w_new_sel} < NP);
    assign w_req_ok     = ({1'b0, r_req_sel} < NP);
    assign w_target     = r_enable && w_req_ok;
    assign w_unused     = ^{wbs_adr_i[1:0], wbs_sel_i[2:1], wbs_dat_i[30:8]};

`ifdef SELECTOR_WATCHDOG_EN
    logic [15:0] r_wdt_reload, r_wdt_cnt, w_wdt_new;
    logic        r_wdt_fired, w_wdt_wr;

    assign w_wdt_wr     = w_req && wbs_we_i && (wbs_adr_i[3:2] == 2'd3);
    assign w_wdt_new    = {wbs_sel_i[1] ? wbs_dat_i[15:8] : r_wdt_reload[15:8],
                           wbs_sel_i[0] ? wbs_dat_i[7:0]  : r_wdt_reload[7:0]};
    assign w_wdt_expire = (r_state == ST_RUN) && (r_wdt_reload != 16'd0) &&
                          (r_wdt_cnt <= 16'd1) && !w_wdt_wr;
    assign w_wdt_fired  = r_wdt_fired;
    assign w_wdt_rd     = r_wdt_reload;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wdt_reload <= '0;
            r_wdt_cnt    <= '0;
            r_wdt_fired  <= 1'b0;
        end else begin
            if (w_wdt_wr) begin
                r_wdt_reload <= w_wdt_new;
                r_wdt_cnt    <= w_wdt_new;
            end else if (r_state != ST_RUN) begin
                r_wdt_cnt <= r_wdt_reload;
            end else if (r_wdt_reload != 16'd0) begin
                r_wdt_cnt <= r_wdt_cnt - 16'd1;
            end
            if (w_ctrl_wr)    r_wdt_fired <= 1'b0;
            if (w_wdt_expire) r_wdt_fired <= 1'b1;
        end
    end
`else
    assign w_wdt_expire = 1'b0;
    assign w_wdt_fired  = 1'b0;
    assign w_wdt_rd     = 16'd0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state;
        w_drain_done = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_target) r_state_next = ST_DRAIN;
            ST_DRAIN: if (r_guard == '0) begin
                w_drain_done = 1'b1;
                r_state_next = w_target ? ST_RUN : ST_IDLE;
            end
            ST_RUN:   if (!w_target || (r_req_sel != r_act_sel) || w_wdt_expire)
                r_state_next = ST_DRAIN;
            default:  r_state_next = ST_IDLE;
        endcase
    end

    assign w_act_sel_next = w_drain_done ? r_req_sel : r_act_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PROJECTS; gi++) begin : g_proj
            assign w_slice_out[gi] = proj_io_out[gi*IO_WIDTH +: IO_WIDTH];
            assign w_slice_oeb[gi] = proj_io_oeb[gi*IO_WIDTH +: IO_WIDTH];
            assign proj_rst[gi]    = !((r_state == ST_RUN) && (r_act_sel == 8'(gi)));
        end
    endgenerate

    // Select on the next act_sel so the pads come up on the same edge RUN is entered.
    always_comb begin
        w_sel_out = '0;
        w_sel_oeb = '1;
        for (int k = 0; k < NUM_PROJECTS; k++) begin
            if (w_act_sel_next == 8'(k)) begin
                w_sel_out = w_slice_out[k];
                w_sel_oeb = w_slice_oeb[k];
            end
        end
    end

    always_comb begin
        w_rd_data = 32'd0;
        case (wbs_adr_i[3:2])
            2'd0:    w_rd_data = {r_enable, 23'd0, r_req_sel};
            2'd1:    w_rd_data = {14'd0, w_wdt_fired, r_bad_sel, 6'd0, r_state, r_act_sel};
            2'd2:    w_rd_data = {16'd0, r_swcount};
            default: w_rd_data = {16'd0, w_wdt_rd};
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_req_sel <= '0;
            r_enable  <= 1'b0;
            r_bad_sel <= 1'b0;
            r_act_sel <= '0;
            r_swcount <= '0;
            r_guard   <= GW'(GUARD_CYCLES - 1);
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_io_out  <= '0;
            r_io_oeb  <= '1;
        end else begin
            if (w_ctrl_wr) begin
                r_req_sel <= w_new_sel;
                if (wbs_sel_i[3]) r_enable <= wbs_dat_i[31];
            end
            if (w_wdt_expire) r_enable <= 1'b0;
            if (w_ctrl_wr && w_new_sel_ok)   r_bad_sel <= 1'b0;
            else if (r_enable && !w_req_ok)  r_bad_sel <= 1'b1;
            // Preloaded outside DRAIN so entry always starts a full guard window.
            r_guard   <= (r_state == ST_DRAIN) ? r_guard - 1'b1 : GW'(GUARD_CYCLES - 1);
            if (w_drain_done) r_swcount <= r_swcount + 16'd1;
            r_act_sel <= w_act_sel_next;
            r_ack     <= w_req;
            r_dat     <= (w_req && !wbs_we_i) ? w_rd_data : 32'd0;
            if (r_state_next == ST_RUN) begin
                r_io_out <= w_sel_out;
                r_io_oeb <= w_sel_oeb;
            end else begin
                r_io_out <= '0;
                r_io_oeb <= '1;
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out    = r_io_out;
    assign io_oeb    = r_io_oeb;

endmodule

// File: tb/tb_wb_project_selector.sv
// Directed bench for wb_project_selector; read responses are checked by a scoreboard monitor on ack.
module tb_wb_project_selector;
    localparam int          NP   = 4;
    localparam int          IW   = 38;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]    sel = 4'd0;
    logic [31:0]   adr = 32'd0, wdat = 32'd0;
    logic          ack;
    logic [31:0]   rdat;
    logic [IW-1:0] pout [NP];
    logic [IW-1:0] poeb [NP];
    logic [NP*IW-1:0] proj_io_out, proj_io_oeb;
    logic [NP-1:0] proj_rst;
    logic [IW-1:0] io_out, io_oeb;
    int            n_cmp = 0;
    int            n_err = 0;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    assign proj_io_out = {pout[3], pout[2], pout[1], pout[0]};
    assign proj_io_oeb = {poeb[3], poeb[2], poeb[1], poeb[0]};

    wb_project_selector #(
        .NUM_PROJECTS(NP), .IO_WIDTH(IW), .BASE_ADDR(BASE), .GUARD_CYCLES(16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .proj_io_out(proj_io_out), .proj_io_oeb(proj_io_oeb), .proj_rst(proj_rst),
        .io_out(io_out), .io_oeb(io_oeb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack adr=%h got_dat=%h want no ack", adr, rdat);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk && (rdat !== mon_e.exp)) begin
                    n_err++;
                    $display("FAIL rd_data adr=%h got %h want %h", adr, rdat, mon_e.exp);
                end else begin
                    $display("txn adr=%h we=%0d wdat=%h rdat=%h", adr, !mon_e.chk, wdat, rdat);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [3:0] off, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] e);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {28'd0, off}; wdat = d; sel = s;
        sb_q.push_back('{!w, e});
        @(posedge clk); #1;
        check("ack_latency", 64'(ack), 64'd1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
        wb(1'b1, off, d, s, 32'd0);
    endtask

    task automatic rd(input logic [3:0] off, input logic [31:0] e);
        wb(1'b0, off, 32'd0, 4'hF, e);
    endtask

    task automatic check_dark(input string name);
        check({name, "_rst"}, 64'(proj_rst), 64'hF);
        check({name, "_oeb"}, 64'(io_oeb), {26'd0, {IW{1'b1}}});
        check({name, "_out"}, 64'(io_out), 64'd0);
    endtask

    // Called on the negedge right after a CTRL write ack; covers the 16 guard cycles.
    task automatic drain_window(input string name);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_dark(name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        pout[0] = 38'h01_2345_6780; poeb[0] = 38'h3F_FFFF_FF00;
        pout[1] = 38'h12_0F0F_0F0F; poeb[1] = 38'h00_0000_00F0;
        pout[2] = 38'h2A_AAAA_5555; poeb[2] = 38'h15_5555_0000;
        pout[3] = 38'h3C_3C3C_3C3C; poeb[3] = 38'h20_0000_000F;

        #1 rst = 1'b1;
        #1;
        check_dark("async_reset");
        check("reset_ack", 64'(ack), 64'd0);
        check("reset_dat", 64'(rdat), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        rd(4'h4, 32'd0);
        rd(4'h8, 32'd0);
        rd(4'h0, 32'd0);

        // Select project 2.
        wr(4'h0, 32'h8000_0002, 4'hF);
        drain_window("drain_to_p2");
        @(negedge clk);
        check("p2_proj_rst", 64'(proj_rst), 64'b1011);
        check("p2_io_oeb", 64'(io_oeb), 64'(38'h15_5555_0000));
        check("p2_io_out", 64'(io_out), 64'(38'h2A_AAAA_5555));
        pout[2] = 38'h05_A5A5_A5A5;
        #1;
        check("p2_out_old", 64'(io_out), 64'(38'h2A_AAAA_5555));
        @(posedge clk); #1;
        check("p2_out_new", 64'(io_out), 64'(38'h05_A5A5_A5A5));
        rd(4'h8, 32'd1);
        rd(4'h4, 32'h0000_0102);

        // Held strobe acks every other cycle.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h8;
        sb_q.push_back('{1'b1, 32'd1});
        sb_q.push_back('{1'b1, 32'd1});
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("held_ack", 64'(ack), 64'(i % 2 == 0));
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;

        // Switch to project 0.
        wr(4'h0, 32'h8000_0000, 4'hF);
        check("still_p2_oeb", 64'(io_oeb), 64'(38'h15_5555_0000));
        drain_window("drain_to_p0");
        @(negedge clk);
        check("p0_proj_rst", 64'(proj_rst), 64'b1110);
        check("p0_io_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FF00));
        check("p0_io_out", 64'(io_out), 64'(38'h01_2345_6780));
        rd(4'h8, 32'd2);
        rd(4'h4, 32'h0000_0100);

        // Out-of-range selection drains to IDLE and flags bad_sel.
        wr(4'h0, 32'h8000_0007, 4'hF);
        drain_window("drain_bad");
        @(negedge clk);
        check_dark("idle_bad");
        rd(4'h8, 32'd3);
        rd(4'h4, 32'h0001_0007);

        // Window miss is never acked.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("miss_no_ack", 64'(ack), 64'd0);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;

`ifdef SELECTOR_WATCHDOG_EN
        wr(4'hC, 32'h0000_1234, 4'hF);
        rd(4'hC, 32'h0000_1234);
`else
        wr(4'hC, 32'h0000_1234, 4'hF);
        rd(4'hC, 32'd0);
`endif

        // Byte write of req_sel only; enable stays set, bad_sel clears.
        wr(4'h0, 32'h0000_0003, 4'b0001);
        rd(4'h0, 32'h8000_0003);
        rd(4'h4, 32'h0000_0207);
        #2 rst = 1'b1;
        #1;
        check_dark("reset_mid_drain");
        @(negedge clk);
        rst = 1'b0;
        rd(4'h4, 32'd0);
        rd(4'h8, 32'd0);
        rd(4'h0, 32'd0);

`ifdef SELECTOR_WATCHDOG_EN
        wr(4'h0, 32'h8000_0001, 4'hF);
        drain_window("drain_to_p1");
        @(negedge clk);
        check("p1_proj_rst", 64'(proj_rst), 64'b1101);
        wr(4'hC, 32'd5, 4'h3);
        for (int i = 0; i < 5; i++) begin
            check("wdt_running", 64'(proj_rst), 64'b1101);
            @(negedge clk);
        end
        check("wdt_expired", 64'(proj_rst), 64'hF);
        rd(4'h4, 32'h0002_0201);
        rd(4'h0, 32'h0000_0001);
`endif

        @(negedge clk); #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
